// File: rtl/wb_slave_router.sv
// wb_slave_router: registered WB decoder/sequencer for UART and exec-mem slaves; WB_ROUTER_TOIRQ_EN drives to_irq_o.
// Latency: slave ack + 2 cycles when mapped, 2 cycles when unmapped, TIMEOUT_CYC + 2 on watchdog expiry.
// Backpressure: one access in flight; upstream holds stb until ack, the watchdog bounds every stall.
module wb_slave_router #(
  parameter logic [11:0] SLV0_BASE   = 12'h300,
  parameter logic [11:0] SLV1_BASE   = 12'h380,
  parameter int unsigned TIMEOUT_CYC = 255,
  parameter logic [31:0] ERR_DATA    = 32'hDEAD_BEEF
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_ni,
  input  logic        wbs_cyc_i,
  input  logic        wbs_stb_i,
  input  logic        wbs_we_i,
  input  logic [3:0]  wbs_sel_i,
  input  logic [31:0] wbs_adr_i,
  input  logic [31:0] wbs_dat_i,
  output logic        wbs_ack_o,
  output logic [31:0] wbs_dat_o,
  output logic [1:0]  slv_cyc_o,
  output logic [1:0]  slv_stb_o,
  output logic        slv_we_o,
  output logic [3:0]  slv_sel_o,
  output logic [31:0] slv_adr_o,
  output logic [31:0] slv_dat_o,
  input  logic [1:0]  slv_ack_i,
  input  logic [31:0] slv0_dat_i,
  input  logic [31:0] slv1_dat_i,
  output logic        to_flag_o,
  input  logic        to_clr_i,
  output logic        to_irq_o
);

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

  localparam logic [15:0] WD_LAST = 16'(TIMEOUT_CYC - 1);

  state_t      state_q, state_d;
  logic [15:0] wd_cnt_q, wd_cnt_d;
  logic [1:0]  req_q, req_d;
  logic        we_q, we_d;
  logic [3:0]  sel_q, sel_d;
  logic [31:0] adr_q, adr_d;
  logic [31:0] wdat_q, wdat_d;
  logic [31:0] resp_dat_q, resp_dat_d;
  logic        ack_q, ack_d;
  logic [31:0] rdat_q, rdat_d;
  logic        flag_q, flag_d;

  logic        hit0, hit1, ack_hit, to_set;
  logic [31:0] slv_rdata;

  // Slave 0 takes precedence if both bases are configured identically.
  assign hit0      = (wbs_adr_i[31:20] == SLV0_BASE);
  assign hit1      = (wbs_adr_i[31:20] == SLV1_BASE) && !hit0;
  assign ack_hit   = |(slv_ack_i & req_q);
  assign slv_rdata = req_q[1] ? slv1_dat_i : slv0_dat_i;

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) state_q <= IDLE;
    else            state_q <= state_d;
  end

  always_comb begin
    state_d    = state_q;
    wd_cnt_d   = '0;
    req_d      = req_q;
    we_d       = we_q;
    sel_d      = sel_q;
    adr_d      = adr_q;
    wdat_d     = wdat_q;
    resp_dat_d = resp_dat_q;
    ack_d      = 1'b0;
    rdat_d     = '0;
    to_set     = 1'b0;
    case (state_q)
      IDLE: begin
        // While our ack is still visible the master has not yet dropped stb.
        if (wbs_cyc_i && wbs_stb_i && !ack_q) begin
          we_d   = wbs_we_i;
          sel_d  = wbs_sel_i;
          adr_d  = wbs_adr_i;
          wdat_d = wbs_dat_i;
          if (hit0 || hit1) begin
            state_d = BUSY;
            req_d   = {hit1, hit0};
          end else begin
            state_d    = RESP;
            resp_dat_d = '0;
          end
        end
      end
      BUSY: begin
        if (!wbs_cyc_i) begin
          state_d = IDLE;
          req_d   = '0;
        end else if (ack_hit) begin
          state_d    = RESP;
          req_d      = '0;
          resp_dat_d = we_q ? 32'h0 : slv_rdata;
        end else if (wd_cnt_q == WD_LAST) begin
          state_d    = RESP;
          req_d      = '0;
          resp_dat_d = ERR_DATA;
          to_set     = 1'b1;
        end else begin
          wd_cnt_d = wd_cnt_q + 16'd1;
        end
      end
      RESP: begin
        state_d = IDLE;
        ack_d   = 1'b1;
        rdat_d  = resp_dat_q;
      end
      default: state_d = IDLE;
    endcase
    flag_d = flag_q;
    if (to_set)        flag_d = 1'b1;
    else if (to_clr_i) flag_d = 1'b0;
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      wd_cnt_q   <= '0;
      req_q      <= '0;
      we_q       <= 1'b0;
      sel_q      <= '0;
      adr_q      <= '0;
      wdat_q     <= '0;
      resp_dat_q <= '0;
      ack_q      <= 1'b0;
      rdat_q     <= '0;
      flag_q     <= 1'b0;
    end else begin
      wd_cnt_q   <= wd_cnt_d;
      req_q      <= req_d;
      we_q       <= we_d;
      sel_q      <= sel_d;
      adr_q      <= adr_d;
      wdat_q     <= wdat_d;
      resp_dat_q <= resp_dat_d;
      ack_q      <= ack_d;
      rdat_q     <= rdat_d;
      flag_q     <= flag_d;
    end
  end

  assign wbs_ack_o = ack_q;
  assign wbs_dat_o = rdat_q;
  assign slv_cyc_o = req_q;
  assign slv_stb_o = req_q;
  assign slv_we_o  = we_q;
  assign slv_sel_o = sel_q;
  assign slv_adr_o = adr_q;
  assign slv_dat_o = wdat_q;
  assign to_flag_o = flag_q;

`ifdef WB_ROUTER_TOIRQ_EN
  assign to_irq_o = flag_q;
`else
  assign to_irq_o = 1'b0;
`endif

endmodule

// File: tb/tb_wb_slave_router.sv
// Bench for wb_slave_router: vector table with a scoreboard of expected acks, plus abort and reset sequences.
module tb_wb_slave_router;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        wbs_cyc_i, wbs_stb_i, wbs_we_i;
  logic [3:0]  wbs_sel_i;
  logic [31:0] wbs_adr_i, wbs_dat_i;
  logic        wbs_ack_o;
  logic [31:0] wbs_dat_o;
  logic [1:0]  slv_cyc_o, slv_stb_o;
  logic        slv_we_o;
  logic [3:0]  slv_sel_o;
  logic [31:0] slv_adr_o, slv_dat_o;
  logic [1:0]  slv_ack_i;
  logic [31:0] slv0_dat_i, slv1_dat_i;
  logic        to_flag_o, to_clr_i, to_irq_o;

`ifdef WB_ROUTER_TOIRQ_EN
  localparam bit IRQ_EN = 1'b1;
`else
  localparam bit IRQ_EN = 1'b0;
`endif

  wb_slave_router #(.TIMEOUT_CYC(8)) dut (
    .wb_clk_i(clk), .wb_rst_ni(rst_n),
    .wbs_cyc_i(wbs_cyc_i), .wbs_stb_i(wbs_stb_i), .wbs_we_i(wbs_we_i),
    .wbs_sel_i(wbs_sel_i), .wbs_adr_i(wbs_adr_i), .wbs_dat_i(wbs_dat_i),
    .wbs_ack_o(wbs_ack_o), .wbs_dat_o(wbs_dat_o),
    .slv_cyc_o(slv_cyc_o), .slv_stb_o(slv_stb_o), .slv_we_o(slv_we_o),
    .slv_sel_o(slv_sel_o), .slv_adr_o(slv_adr_o), .slv_dat_o(slv_dat_o),
    .slv_ack_i(slv_ack_i), .slv0_dat_i(slv0_dat_i), .slv1_dat_i(slv1_dat_i),
    .to_flag_o(to_flag_o), .to_clr_i(to_clr_i), .to_irq_o(to_irq_o)
  );

  always #5 clk = ~clk;

  int cyc_cnt = 0;
  always @(posedge clk) cyc_cnt++;

  int pass_cnt = 0;
  int chk_cnt  = 0;

  function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    chk_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endfunction

  // Slave model: the selected slave acks in cycle m_lat after its stb rises (0 = never);
  // with m_noise set, every slave whose stb is low acks continuously.
  int         m_lat = 0;
  logic       m_noise = 1'b0;
  logic [1:0] extra_ack = 2'b00;
  logic [1:0] m_ack;
  int         scnt[2];

  always @(posedge clk) begin
    #1;
    for (int i = 0; i < 2; i++) begin
      if (slv_stb_o[i] === 1'b1) scnt[i]++; else scnt[i] = 0;
      if (slv_stb_o[i] === 1'b1 && m_lat != 0 && scnt[i] == m_lat) m_ack[i] = 1'b1;
      else if (slv_stb_o[i] !== 1'b1 && m_noise) m_ack[i] = 1'b1;
      else m_ack[i] = 1'b0;
    end
    slv_ack_i = m_ack | extra_ack;
  end

  typedef struct {
    logic        we;
    logic [31:0] adr;
    logic [31:0] wdat;
    logic [3:0]  sel;
    int          lat;
    logic [31:0] rd;
    logic        noise;
    int          clr_at;
    logic [1:0]  exp_stb;
    logic [31:0] exp_dat;
    int          exp_lat;
    logic        exp_flag;
  } vec_t;

  typedef struct {
    int          idx;
    logic [31:0] dat;
    int          cyc;
  } exp_t;

  vec_t vecs[12];
  exp_t exp_q[$];
  exp_t mon_e;

  always @(negedge clk) begin
    if (rst_n === 1'b1 && wbs_ack_o === 1'b1) begin
      if (exp_q.size() == 0) begin
        chk_cnt++;
        $display("FAIL unexpected_ack: got ack with dat %h, expected no ack", wbs_dat_o);
      end else begin
        mon_e = exp_q.pop_front();
        chk($sformatf("v%0d_dat", mon_e.idx), wbs_dat_o, mon_e.dat);
        chk($sformatf("v%0d_ack_cycle", mon_e.idx), 32'(cyc_cnt), 32'(mon_e.cyc));
      end
    end
  end

  task automatic rst_chk(input string pfx);
    chk({pfx, "_ctl"}, {20'd0, wbs_ack_o, slv_cyc_o, slv_stb_o, slv_we_o, slv_sel_o, to_flag_o, to_irq_o}, 32'd0);
    chk({pfx, "_rdat"}, wbs_dat_o, 32'd0);
    chk({pfx, "_adr"}, slv_adr_o, 32'd0);
    chk({pfx, "_wdat"}, slv_dat_o, 32'd0);
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    bit got = 1'b0;
    @(posedge clk); #2;
    wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1; wbs_we_i = v.we;
    wbs_adr_i = v.adr; wbs_dat_i = v.wdat; wbs_sel_i = v.sel;
    m_lat = v.lat; m_noise = v.noise; to_clr_i = 1'b0;
    slv0_dat_i = v.exp_stb[1] ? ~v.rd : v.rd;
    slv1_dat_i = v.exp_stb[1] ? v.rd : ~v.rd;
    exp_q.push_back('{idx, v.exp_dat, cyc_cnt + v.exp_lat});
    for (int n = 1; n <= 40; n++) begin
      @(posedge clk); #2;
      to_clr_i = (n == v.clr_at);
      if (n == 1) begin
        chk($sformatf("v%0d_slv_stb", idx), {30'd0, slv_stb_o}, {30'd0, v.exp_stb});
        chk($sformatf("v%0d_slv_cyc", idx), {30'd0, slv_cyc_o}, {30'd0, v.exp_stb});
        chk($sformatf("v%0d_slv_adr", idx), slv_adr_o, v.adr);
        chk($sformatf("v%0d_slv_wdat", idx), slv_dat_o, v.wdat);
        chk($sformatf("v%0d_slv_selwe", idx), {27'd0, slv_sel_o, slv_we_o}, {27'd0, v.sel, v.we});
      end
      if (wbs_ack_o === 1'b1) begin
        got = 1'b1;
        break;
      end
    end
    if (!got) chk($sformatf("v%0d_ack_seen", idx), 32'd0, 32'd1);
    // Master keeps stb through the ack cycle, so the router must not re-capture it.
    @(posedge clk); #2;
    wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0; to_clr_i = 1'b0;
    chk($sformatf("v%0d_after_ack", idx), {29'd0, wbs_ack_o, slv_cyc_o}, 32'd0);
    chk($sformatf("v%0d_after_dat", idx), wbs_dat_o, 32'd0);
    chk($sformatf("v%0d_flag", idx), {31'd0, to_flag_o}, {31'd0, v.exp_flag});
    chk($sformatf("v%0d_irq", idx), {31'd0, to_irq_o}, {31'd0, v.exp_flag & IRQ_EN});
  endtask

  initial begin
    rst_n = 1'b1;
    wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0; wbs_we_i = 1'b0;
    wbs_sel_i = 4'h0; wbs_adr_i = 32'h0; wbs_dat_i = 32'h0;
    slv0_dat_i = 32'h0; slv1_dat_i = 32'h0; to_clr_i = 1'b0;

    //          we    adr             wdat            sel   lat rd              noise clr exp_stb exp_dat         lat flag
    vecs[0]  = '{1'b0, 32'h3000_0004, 32'h0000_0000, 4'hF, 3, 32'h0000_0055, 1'b0, 0, 2'b01, 32'h0000_0055, 5,  1'b0};
    vecs[1]  = '{1'b1, 32'h3800_0010, 32'hA5A5_0001, 4'hF, 2, 32'h0000_1234, 1'b0, 0, 2'b10, 32'h0000_0000, 4,  1'b0};
    vecs[2]  = '{1'b0, 32'h2000_0000, 32'h0000_0000, 4'hF, 0, 32'h0000_7777, 1'b1, 0, 2'b00, 32'h0000_0000, 2,  1'b0};
    vecs[3]  = '{1'b0, 32'h380F_FFF0, 32'h0000_0000, 4'hF, 1, 32'hCAFE_F00D, 1'b0, 0, 2'b10, 32'hCAFE_F00D, 3,  1'b0};
    vecs[4]  = '{1'b1, 32'h300F_FFFC, 32'h0BAD_CAFE, 4'h3, 7, 32'h0000_4444, 1'b1, 0, 2'b01, 32'h0000_0000, 9,  1'b0};
    vecs[5]  = '{1'b0, 32'h3000_0008, 32'h0000_0000, 4'hF, 8, 32'h0000_8888, 1'b0, 0, 2'b01, 32'h0000_8888, 10, 1'b0};
    vecs[6]  = '{1'b0, 32'h3000_0000, 32'h0000_0000, 4'hF, 0, 32'h0000_1111, 1'b1, 0, 2'b01, 32'hDEAD_BEEF, 10, 1'b1};
    vecs[7]  = '{1'b0, 32'h3800_0000, 32'h0000_0000, 4'hF, 0, 32'h0000_2222, 1'b0, 8, 2'b10, 32'hDEAD_BEEF, 10, 1'b1};
    vecs[8]  = '{1'b0, 32'h3100_0000, 32'h0000_0000, 4'hF, 0, 32'h0000_0000, 1'b0, 1, 2'b00, 32'h0000_0000, 2,  1'b0};
    vecs[9]  = '{1'b0, 32'h3800_0004, 32'h0000_0000, 4'h1, 0, 32'h0000_0000, 1'b0, 0, 2'b10, 32'hDEAD_BEEF, 10, 1'b1};
    vecs[10] = '{1'b1, 32'h0000_0040, 32'h0000_0001, 4'h1, 0, 32'h0000_0000, 1'b0, 0, 2'b00, 32'h0000_0000, 2,  1'b1};
    vecs[11] = '{1'b0, 32'h0000_0080, 32'h0000_0000, 4'h2, 0, 32'h0000_0000, 1'b0, 0, 2'b00, 32'h0000_0000, 2,  1'b0};

    #1 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    rst_chk("reset");
    rst_n = 1'b1;

    for (int i = 0; i < 10; i++) run_vec(i, vecs[i]);

    // Abort: cyc dropped mid-BUSY, then a late slave ack must not reach upstream.
    @(posedge clk); #2;
    wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1; wbs_we_i = 1'b0;
    wbs_adr_i = 32'h3000_0020; m_lat = 0; m_noise = 1'b0;
    repeat (3) begin @(posedge clk); #2; end
    wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0;
    @(posedge clk); #2;
    chk("abort_slv", {28'd0, slv_cyc_o, slv_stb_o}, 32'd0);
    extra_ack = 2'b01;
    repeat (2) begin @(posedge clk); #2; end
    extra_ack = 2'b00;
    chk("abort_no_ack", {31'd0, wbs_ack_o}, 32'd0);
    run_vec(10, vecs[10]);

    // Reset asserted while a slave access is outstanding.
    @(posedge clk); #2;
    wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1; wbs_we_i = 1'b1;
    wbs_adr_i = 32'h3800_0008; wbs_dat_i = 32'h1357_9BDF; m_lat = 0;
    repeat (3) begin @(posedge clk); #2; end
    chk("midrst_busy", {30'd0, slv_stb_o}, 32'd2);
    rst_n = 1'b0;
    wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0;
    #1;
    rst_chk("midrst");
    @(posedge clk); #2;
    rst_n = 1'b1;
    run_vec(11, vecs[11]);

    repeat (5) @(posedge clk);
    chk("sb_drain", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation still running at %0t, expected completion", $time);
    $fatal(1);
  end

endmodule
